int_to_fp_pipe: RTL and testbench
=================================

# int_to_fp_pipe

Three-stage pipelined integer-to-floating-point converter for the FPU, the reverse path of the float-to-integer core. Accepts a 32- or 64-bit signed or unsigned integer with a RISC-V rounding mode and produces an IEEE-754 value of parameterized format plus exception flags. A valid/ready handshake is used on both sides, and a synchronous flush kills in-flight operations. It sits in the FPU conversion lane alongside the float-to-int core and shares the same op encoding.

## Interface
- EXPWIDTH, 8, exponent width of the result format (must be ≥ 8).
- PRECISION, 24, significand width including hidden bit.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. Synchronous and active-high.
- flush_i  in  1  synchronous kill of all in-flight ops.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  converter can accept a request.
- a_i  in  64  integer operand. Only [31:0] is used when op_i[1]=0.
- rm_i  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- op_i  in  2  [0]=signed, [1]=64-bit source.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  EXPWIDTH+PRECISION  packed float {sign, exp, frac}.
- fflags_o  out  5  {NV, DZ, OF, UF, NX}.

## Operation
- Operand selection:
  - op_i[1]=0: source is a_i[31:0], sign-extended when op_i[0]=1, zero-extended otherwise.
  - op_i[1]=1: source is the full a_i.
  - sign = op_i[0] & source[63]. abs = sign ? −source : source (64-bit; −2^63 maps to 0x8000_0000_0000_0000).
- Stage S1 (register): sign, abs, rm.
- Stage S2 (register):
  - lzc = leading-zero count of abs (0..63); zero flag = (abs==0).
  - norm = abs << lzc, so the MSB is at bit 63.
  - exp = EXPBIAS + 63 − lzc, where EXPBIAS = 2^(EXPWIDTH−1)−1.
- Stage S3 (register, drives outputs):
  - mant = norm[62:64−PRECISION]; round = norm[63−PRECISION]; sticky = |norm[62−PRECISION:0].
  - Round up when:
    - RNE: round & (sticky | mant[0]).
    - RTZ: never.
    - RDN: sign & (round | sticky).
    - RUP: !sign & (round | sticky).
    - RMM: round.
  - Carry out of mant: mant becomes 0 and exp becomes exp+1.
  - NX = round | sticky.
- Zero input gives result +0 (all zeros) and fflags 0, for every rm and for signed ops.
- Flag limits:
  - NV, DZ, UF are always 0.
  - OF is always 0; it is unreachable for EXPWIDTH ≥ 8, since the maximum exp is EXPBIAS+64.
  - fflags_o = {0,0,0,0,NX}.
- Reserved rm values 5–7 behave as RTZ.

## Timing
- Latency is 3 cycles from input handshake to out_valid_o, given no backpressure.
- Throughput is 1 op/cycle.
- Pipeline control:
  - Global advance enable en = !out_valid_o | out_ready_i.
  - in_ready_o = en.
  - A request is accepted when in_valid_i & in_ready_o.
  - When en=1, every stage's valid and data shift forward one stage. An empty S1/S2 slot is a bubble and moves like data.
  - When en=0, all stage registers hold. result_o and fflags_o stay stable while out_valid_o=1 and out_ready_i=0.
- flush_i=1 clears all stage valid bits at the next edge.
  - A request presented in the same cycle is dropped.
  - flush has priority over a simultaneous handshake.
- rst=1 sets all valid bits to 0, result_o to 0 and fflags_o to 0 at the next edge, including mid-operation. in_ready_o is 1 in the cycle after reset.
- out_valid_o deasserts after the output handshake unless S2 held a valid op.

## Test plan
- Signed 32-bit a_i=0xFFFF_FFFF, rm=RNE -> result_o=0xBF800000, fflags=0, valid 3 cycles after accept.
- Unsigned 32-bit a_i=0xFFFF_FFFF:
  - RNE -> 0x4F800000, NX=1.
  - RTZ -> 0x4F7FFFFF, NX=1.
- Signed 32-bit a_i=0x0100_0001:
  - RNE -> 0x4B800000, NX=1.
  - RUP -> 0x4B800001.
  - RMM -> 0x4B800001.
  - RDN -> 0x4B800000.
- Signed 64-bit 0x8000_0000_0000_0000 -> 0xDF000000, fflags=0. a_i=0 with any op/rm -> 0x00000000, fflags=0.
- Back-to-back 3 ops, then out_ready_i=0 for 5 cycles:
  - in_ready_o=0 and outputs frozen during the stall.
  - In-order delivery of all 3 results afterwards, with no loss or duplication.
- Assert flush_i with 2 ops in flight plus a new request -> no out_valid_o afterward. Repeat with rst in place of flush -> outputs 0 next cycle.

Source files
------------

// File: rtl/int_to_fp_pipe.sv
// Three-stage pipelined signed/unsigned 32/64-bit integer to IEEE-754 converter.
// S1 takes the magnitude, S2 normalizes it and S3 rounds into the output registers.
module int_to_fp_pipe #(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [63:0]                   a_i,
  input  logic [2:0]                    rm_i,
  input  logic [1:0]                    op_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [EXPWIDTH+PRECISION-1:0] result_o,
  output logic [4:0]                    fflags_o
);

  localparam int EXPBIAS = (1 << (EXPWIDTH - 1)) - 1;
  localparam logic [EXPWIDTH-1:0] EXP_TOP = EXPWIDTH'(EXPBIAS + 63);

  function automatic logic [5:0] lzc64(input logic [63:0] v);
    lzc64 = 6'd0;
    for (int i = 0; i < 64; i++)
      if (v[i]) lzc64 = 6'(63 - i);
  endfunction

  logic        en;
  logic [63:0] src;
  logic        in_sign;
  logic [63:0] in_abs;

  logic        s1_valid, s1_sign;
  logic [63:0] s1_abs;
  logic [2:0]  s1_rm;
  logic [5:0]  s1_lzc;

  logic                s2_valid, s2_sign, s2_zero;
  logic [EXPWIDTH-1:0] s2_exp;
  logic [62:0]         s2_norm;
  logic [2:0]          s2_rm;

  logic [PRECISION-2:0]        mant;
  logic                        rnd, sticky, round_up;
  logic [PRECISION-1:0]        mant_inc;
  logic [EXPWIDTH-1:0]         exp_out;
  logic [EXPWIDTH+PRECISION-1:0] res_nxt;
  logic [4:0]                  flags_nxt;

  assign en         = !out_valid_o | out_ready_i;
  assign in_ready_o = en;

  // 32-bit sources are widened first so one 64-bit negate serves every op.
  always_comb begin
    src = a_i;
    if (!op_i[1])
      src = op_i[0] ? {{32{a_i[31]}}, a_i[31:0]} : {32'd0, a_i[31:0]};
    in_sign = op_i[0] & src[63];
    in_abs  = in_sign ? (~src + 64'd1) : src;
  end

  assign s1_lzc = lzc64(s1_abs);

  always_comb begin
    mant   = s2_norm[62:64-PRECISION];
    rnd    = s2_norm[63-PRECISION];
    sticky = |s2_norm[62-PRECISION:0];
    case (s2_rm)
      3'd0:    round_up = rnd & (sticky | mant[0]);
      3'd2:    round_up = s2_sign & (rnd | sticky);
      3'd3:    round_up = !s2_sign & (rnd | sticky);
      3'd4:    round_up = rnd;
      default: round_up = 1'b0;
    endcase
    mant_inc  = {1'b0, mant} + PRECISION'(round_up);
    // A carry out of the fraction leaves it all zeros, so only the exponent moves.
    exp_out   = mant_inc[PRECISION-1] ? s2_exp + EXPWIDTH'(1) : s2_exp;
    res_nxt   = s2_zero ? '0 : {s2_sign, exp_out, mant_inc[PRECISION-2:0]};
    flags_nxt = s2_zero ? 5'd0 : {4'd0, rnd | sticky};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_abs      <= '0;
      s1_rm       <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_zero     <= 1'b0;
      s2_exp      <= '0;
      s2_norm     <= '0;
      s2_rm       <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      fflags_o    <= '0;
    end else begin
      if (en) begin
        s1_sign  <= in_sign;
        s1_abs   <= in_abs;
        s1_rm    <= rm_i;
        s2_sign  <= s1_sign;
        s2_zero  <= (s1_abs == 64'd0);
        s2_exp   <= EXP_TOP - EXPWIDTH'(s1_lzc);
        s2_norm  <= 63'(s1_abs << s1_lzc);
        s2_rm    <= s1_rm;
        result_o <= res_nxt;
        fflags_o <= flags_nxt;
      end
      if (flush_i) begin
        s1_valid    <= 1'b0;
        s2_valid    <= 1'b0;
        out_valid_o <= 1'b0;
      end else if (en) begin
        s1_valid    <= in_valid_i;
        s2_valid    <= s1_valid;
        out_valid_o <= s2_valid;
      end
    end
  end

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Scoreboard bench for int_to_fp_pipe (binary32 configuration): directed vectors,
// latency, stall, flush, reset and randomized traffic with random backpressure.
module tb_int_to_fp_pipe;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] a_i;
  logic [2:0]  rm_i;
  logic [1:0]  op_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  logic use_rand, rand_rdy, fixed_rdy;
  exp_t sb[$];
  exp_t mon_exp;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_out    = 0;

  assign out_ready_i = use_rand ? rand_rdy : fixed_rdy;

  int_to_fp_pipe #(.EXPWIDTH(8), .PRECISION(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .rm_i       (rm_i),
    .op_i       (op_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .fflags_o   (fflags_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rand_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Rounds from the exact remainder against one half ulp, independent of round/sticky bits.
  function automatic void refConvert(input logic [63:0] a, input logic [1:0] op, input logic [2:0] rm,
                                     output logic [31:0] res, output logic [4:0] flags);
    logic [63:0] src, mag, q, rem, half;
    logic        neg, nx, up;
    int          p, e;
    if (op[1]) src = a;
    else if (op[0]) src = {{32{a[31]}}, a[31:0]};
    else src = {32'd0, a[31:0]};
    neg   = op[0] && src[63];
    mag   = neg ? (~src + 64'd1) : src;
    res   = 32'd0;
    flags = 5'd0;
    if (mag == 64'd0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
      rem = 64'd0;
      half = 64'd0;
    end else begin
      q = mag >> (p - 23);
      rem = mag & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
    end
    nx = (rem != 64'd0);
    case (rm)
      3'd0:    up = nx && ((rem > half) || (rem == half && q[0]));
      3'd2:    up = neg && nx;
      3'd3:    up = !neg && nx;
      3'd4:    up = nx && (rem >= half);
      default: up = 1'b0;
    endcase
    q = q + {63'd0, up};
    e = 127 + p;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
    res   = {neg, 8'(e), q[22:0]};
    flags = {4'd0, nx};
  endfunction

  task automatic applyStimulus(input logic [63:0] a, input logic [1:0] op, input logic [2:0] rm,
                               input logic [31:0] e_res, input logic [4:0] e_flags);
    exp_t ent;
    bit   done;
    done = 1'b0;
    a_i = a;
    op_i = op;
    rm_i = rm;
    in_valid_i = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = in_ready_o && !flush_i && !rst;
      @(posedge clk);
      #1;
    end
    if (done) begin
      ent.res = e_res;
      ent.flags = e_flags;
      sb.push_back(ent);
    end else begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic applyModel(input logic [63:0] a, input logic [1:0] op, input logic [2:0] rm);
    logic [31:0] r;
    logic [4:0]  f;
    refConvert(a, op, rm, r, f);
    applyStimulus(a, op, rm, r, f);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Compare every delivered result, in order, against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", {32'd0, result_o}, 64'hDEAD);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("result", {32'd0, result_o}, {32'd0, mon_exp.res});
        checkOutput("fflags", {59'd0, fflags_o}, {59'd0, mon_exp.flags});
        n_out++;
      end
    end
  end

  initial begin
    int lat;
    int base;
    logic [63:0] r;
    rst = 1'b1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    a_i = '0;
    rm_i = '0;
    op_i = '0;
    use_rand = 1'b0;
    fixed_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("reset_ready", {63'd0, in_ready_o}, 64'd1);
    checkOutput("reset_result", {32'd0, result_o}, 64'd0);
    checkOutput("reset_fflags", {59'd0, fflags_o}, 64'd0);

    $display("[TB] latency and directed vectors");
    applyStimulus(64'hFFFF_FFFF, 2'b01, 3'd0, 32'hBF80_0000, 5'd0);
    in_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid_o && lat < 20);
    checkOutput("latency", 64'(lat), 64'd3);
    waitDrain("drain_latency");

    applyStimulus(64'hFFFF_FFFF, 2'b00, 3'd0, 32'h4F80_0000, 5'd1);
    applyStimulus(64'hFFFF_FFFF, 2'b00, 3'd1, 32'h4F7F_FFFF, 5'd1);
    applyStimulus(64'h0100_0001, 2'b01, 3'd0, 32'h4B80_0000, 5'd1);
    applyStimulus(64'h0100_0001, 2'b01, 3'd3, 32'h4B80_0001, 5'd1);
    applyStimulus(64'h0100_0001, 2'b01, 3'd4, 32'h4B80_0001, 5'd1);
    applyStimulus(64'h0100_0001, 2'b01, 3'd2, 32'h4B80_0000, 5'd1);
    applyStimulus(64'h8000_0000_0000_0000, 2'b11, 3'd0, 32'hDF00_0000, 5'd0);
    applyStimulus(64'hFFFF_FFFF_0000_0000, 2'b00, 3'd0, 32'h0000_0000, 5'd0);
    applyStimulus(64'h0100_0001, 2'b00, 3'd6, 32'h4B80_0000, 5'd1);
    for (int op = 0; op < 4; op++)
      for (int rm = 0; rm < 5; rm += 2)
        applyStimulus(64'd0, 2'(op), 3'(rm), 32'd0, 5'd0);
    in_valid_i = 1'b0;
    waitDrain("drain_directed");

    $display("[TB] stall with three ops in flight");
    fixed_rdy = 1'b0;
    base = n_out;
    applyStimulus(64'hFFFF_FFFF, 2'b00, 3'd1, 32'h4F7F_FFFF, 5'd1);
    applyStimulus(64'h0100_0001, 2'b01, 3'd3, 32'h4B80_0001, 5'd1);
    applyStimulus(64'h8000_0000_0000_0000, 2'b11, 3'd0, 32'hDF00_0000, 5'd0);
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
      checkOutput("stall_valid", {63'd0, out_valid_o}, 64'd1);
      checkOutput("stall_result", {32'd0, result_o}, 64'h4F7F_FFFF);
      checkOutput("stall_fflags", {59'd0, fflags_o}, 64'd1);
    end
    @(posedge clk);
    #1;
    fixed_rdy = 1'b1;
    waitDrain("drain_stall");
    checkOutput("stall_delivered", 64'(n_out - base), 64'd3);

    $display("[TB] flush with two ops in flight");
    applyStimulus(64'd1234, 2'b00, 3'd0, 32'h449A_4000, 5'd0);
    applyStimulus(64'd5678, 2'b00, 3'd0, 32'h45B1_7000, 5'd0);
    a_i = 64'd99;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("flush_no_valid", {63'd0, out_valid_o}, 64'd0);
    end

    $display("[TB] reset with ops in flight");
    fixed_rdy = 1'b0;
    applyStimulus(64'hFFFF_FFFF, 2'b00, 3'd1, 32'h4F7F_FFFF, 5'd1);
    applyStimulus(64'h0100_0001, 2'b01, 3'd3, 32'h4B80_0001, 5'd1);
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre_reset_valid", {63'd0, out_valid_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    checkOutput("rst_valid", {63'd0, out_valid_o}, 64'd0);
    checkOutput("rst_result", {32'd0, result_o}, 64'd0);
    checkOutput("rst_fflags", {59'd0, fflags_o}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    fixed_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_no_valid", {63'd0, out_valid_o}, 64'd0);
    end
    @(posedge clk);
    #1;

    $display("[TB] random traffic with backpressure");
    use_rand = 1'b1;
    base = n_out;
    for (int i = 0; i < 60; i++) begin
      r = {$urandom, $urandom};
      r = r >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) r = 64'd0;
      applyModel(r, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 4) == 0) begin
        in_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid_i = 1'b0;
    use_rand = 1'b0;
    fixed_rdy = 1'b1;
    waitDrain("drain_random");
    checkOutput("random_delivered", 64'(n_out - base), 64'd60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
